// File: rtl/dadda_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Step indices select operand halves; the shift table aligns each partial product.
package dadda_seq_pkg;

  localparam int HALF_W = 16;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  typedef logic [1:0] step_t;

  localparam logic [5:0] SHIFT_TBL [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

  function automatic logic [5:0] step_shift(input step_t s);
    return SHIFT_TBL[s];
  endfunction

endpackage

// File: rtl/dadda_16.sv
// 16x16 unsigned multiplier core: carry-save partial-product reduction
// followed by a single carry-propagate add.
module dadda_16
  import dadda_seq_pkg::*;
(
  input  logic [HALF_W-1:0] A,
  input  logic [HALF_W-1:0] B,
  output logic [OP_W-1:0]   Y
);

  logic [OP_W-1:0] s;
  logic [OP_W-1:0] c;
  logic [OP_W-1:0] pp;
  logic [OP_W-1:0] t;

  always_comb begin
    s  = '0;
    c  = '0;
    pp = '0;
    t  = '0;
    for (int i = 0; i < HALF_W; i++) begin
      pp = B[i] ? (OP_W'(A) << i) : '0;
      t  = s ^ c ^ pp;
      // Carries leaving bit 31 are dropped; the product fits in 32 bits.
      c  = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = t;
    end
    Y = s + c;
  end

endmodule

// File: rtl/dadda_mul32_seq.sv
// Sequential 32x32 unsigned multiplier sharing one dadda_16 core
// over four steps, with valid/ready handshakes on both sides.
module dadda_mul32_seq
  import dadda_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] y,
  output logic              busy
);

  state_t              state;
  step_t               step;
  logic [OP_W-1:0]     op_a;
  logic [OP_W-1:0]     op_b;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   sum;
  logic [HALF_W-1:0]   mul_a;
  logic [HALF_W-1:0]   mul_b;
  logic [OP_W-1:0]     prod;

  always_comb begin
    mul_a = op_a[HALF_W-1:0];
    mul_b = op_b[HALF_W-1:0];
    unique case (step)
      2'd0: ;
      2'd1: mul_b = op_b[OP_W-1:HALF_W];
      2'd2: mul_a = op_a[OP_W-1:HALF_W];
      2'd3: begin
        mul_a = op_a[OP_W-1:HALF_W];
        mul_b = op_b[OP_W-1:HALF_W];
      end
    endcase
  end

  dadda_16 u_core (
    .A (mul_a),
    .B (mul_b),
    .Y (prod)
  );

  assign sum = acc + (PROD_W'(prod) << step_shift(step));

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          step <= step + 2'd1;
          // Last partial sum goes straight to y so acc is free next op.
          if (step == 2'd3) begin
            y         <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
